// File: rtl/fadd_pkg.sv
// ---------------------------------------------------------------------------
// fadd_pkg
// Shared definitions for the shared floating-point adder front end:
//   - FSM state encoding (3-bit codes plus the enum built on them)
//   - FP_WIDTH, the IEEE754 single-precision word width
//   - well-known result words (error marker, +/- infinity)
// No ports; imported by fadd_share_arbiter.
// ---------------------------------------------------------------------------
package fadd_pkg;

  localparam int FP_WIDTH = 32;

  // Raw state codes; kept as plain localparams so other blocks can decode
  // a state word without depending on the enum type.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_RESP  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT,
    S_RESP  = ST_RESP,
    S_GAP   = ST_GAP
  } fsmState_e;

  // Returned instead of a sum when the unit never reports done.
  localparam logic [FP_WIDTH-1:0] FP_ERR_WORD = 32'hFFFF_FFFF;
  localparam logic [FP_WIDTH-1:0] FP_POS_INF  = 32'h7F80_0000;
  localparam logic [FP_WIDTH-1:0] FP_NEG_INF  = 32'hFF80_0000;

endpackage

// File: rtl/fadd_share_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker: grants the first set request
// bit at or after the pointer, wrapping modulo N.
// Ports:
//   req       [N-1:0]         request vector
//   ptr       [$clog2(N)-1:0] highest-priority index (must be < N)
//   grant     [N-1:0]         one-hot grant, all zero when req is zero
//   grantIdx  [$clog2(N)-1:0] index of the granted bit, 0 when none
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grantIdx
);

  localparam int IW = $clog2(N);

  logic          found_s;
  logic [IW-1:0] candIdx_s;
  int            sum_s;

  // Walk the N candidates starting at ptr; first set bit wins.
  always_comb begin
    grant     = '0;
    grantIdx  = '0;
    found_s   = 1'b0;
    candIdx_s = '0;
    sum_s     = '0;
    for (int k = 0; k < N; k++) begin
      sum_s = int'(ptr) + k;
      if (sum_s < N) begin
        candIdx_s = IW'(sum_s);
      end else begin
        candIdx_s = IW'(sum_s - N);
      end
      if (!found_s && req[candIdx_s]) begin
        found_s           = 1'b1;
        grant[candIdx_s]  = 1'b1;
        grantIdx          = candIdx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/fadd_share_arbiter.sv
// ---------------------------------------------------------------------------
// fadd_share_arbiter
// Shares one single-precision add/sub unit between N_REQ requesters.
// Round-robin grant, level start/done handshake with the unit, a one-cycle
// ack per result, a timeout for a unit that never answers, and a fixed
// start-low gap between operations so the unit always sees a fresh edge.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req/req_sub         per-requester request level and op (1 = subtract)
//   req_x/req_y         per-requester operands, slice i = [32*i+31:32*i]
//   ack                 one-hot one-cycle result pulse
//   rsp_result/rsp_err  result word / timeout flag, valid only with ack
//   busy                high whenever the FSM is not idle
//   fu_start/fu_sub     level start and op select to the unit
//   fu_x/fu_y           operands to the unit (held stable through the gap)
//   fu_done/fu_result   unit ready level and result word
// ---------------------------------------------------------------------------
module fadd_share_arbiter
  import fadd_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64,
  parameter int GAP     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          req_sub,
  input  logic [FP_WIDTH*N_REQ-1:0] req_x,
  input  logic [FP_WIDTH*N_REQ-1:0] req_y,
  output logic [N_REQ-1:0]          ack,
  output logic [FP_WIDTH-1:0]       rsp_result,
  output logic                      rsp_err,
  output logic                      busy,
  output logic                      fu_start,
  output logic                      fu_sub,
  output logic [FP_WIDTH-1:0]       fu_x,
  output logic [FP_WIDTH-1:0]       fu_y,
  input  logic                      fu_done,
  input  logic [FP_WIDTH-1:0]       fu_result
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT);
  localparam int GW = $clog2(GAP);

  localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  fsmState_e           state_r;
  logic [IW-1:0]       ptr_r;
  logic [IW-1:0]       grantIdx_r;
  logic [N_REQ-1:0]    grantOh_r;
  logic [TW-1:0]       tmoCnt_r;
  logic [GW-1:0]       gapCnt_r;

  logic [N_REQ-1:0]    arbGrant_s;
  logic [IW-1:0]       arbIdx_s;
  logic [FP_WIDTH-1:0] selX_s;
  logic [FP_WIDTH-1:0] selY_s;
  logic                selSub_s;

  rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .req      (req),
    .ptr      (ptr_r),
    .grant    (arbGrant_s),
    .grantIdx (arbIdx_s)
  );

  // Operand mux for the requester the arbiter currently picks.
  always_comb begin
    selX_s   = '0;
    selY_s   = '0;
    selSub_s = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arbIdx_s == IW'(i)) begin
        selX_s   = req_x[i*FP_WIDTH +: FP_WIDTH];
        selY_s   = req_y[i*FP_WIDTH +: FP_WIDTH];
        selSub_s = req_sub[i];
      end else begin
        selSub_s = selSub_s;
      end
    end
  end

  // Control FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      ptr_r      <= '0;
      grantIdx_r <= '0;
      grantOh_r  <= '0;
      tmoCnt_r   <= '0;
      gapCnt_r   <= '0;
      ack        <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
      fu_start   <= 1'b0;
      fu_sub     <= 1'b0;
      fu_x       <= '0;
      fu_y       <= '0;
    end else begin
      // Response fields are only non-zero during the single RESP cycle.
      ack        <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (|req) begin
            grantIdx_r <= arbIdx_s;
            grantOh_r  <= arbGrant_s;
            fu_sub     <= selSub_s;
            fu_x       <= selX_s;
            fu_y       <= selY_s;
            // Start rises together with the ISSUE state.
            fu_start   <= 1'b1;
            busy       <= 1'b1;
            state_r    <= S_ISSUE;
          end else begin
            fu_start   <= 1'b0;
            busy       <= 1'b0;
            state_r    <= S_IDLE;
          end
        end
        S_ISSUE: begin
          fu_start <= 1'b1;
          tmoCnt_r <= '0;
          state_r  <= S_WAIT;
        end
        S_WAIT: begin
          // Done wins over a timeout expiring in the same cycle.
          if (fu_done) begin
            rsp_result <= fu_result;
            rsp_err    <= 1'b0;
            ack        <= grantOh_r;
            fu_start   <= 1'b0;
            state_r    <= S_RESP;
          end else if (tmoCnt_r == TMO_LAST) begin
            rsp_result <= FP_ERR_WORD;
            rsp_err    <= 1'b1;
            ack        <= grantOh_r;
            fu_start   <= 1'b0;
            state_r    <= S_RESP;
          end else begin
            tmoCnt_r   <= tmoCnt_r + TW'(1);
            fu_start   <= 1'b1;
            state_r    <= S_WAIT;
          end
        end
        S_RESP: begin
          // The served requester drops to lowest priority.
          if (grantIdx_r == LAST_IDX) begin
            ptr_r <= '0;
          end else begin
            ptr_r <= grantIdx_r + IW'(1);
          end
          fu_start <= 1'b0;
          gapCnt_r <= '0;
          state_r  <= S_GAP;
        end
        S_GAP: begin
          fu_start <= 1'b0;
          if (gapCnt_r == GAP_LAST) begin
            busy    <= 1'b0;
            state_r <= S_IDLE;
          end else begin
            gapCnt_r <= gapCnt_r + GW'(1);
            state_r  <= S_GAP;
          end
        end
        default: begin
          fu_start <= 1'b0;
          busy     <= 1'b0;
          state_r  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
